// File: rtl/mem_dp_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_dp_pkg
// Description : Shared definitions for the dual-port data memory: access-size
//               codes, clear-sequencer state encoding and the write-data
//               formatting helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_dp_pkg;

    // Access size codes (2'b11 is treated as full word)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_FULL = 2'b10;

    // Clear-sequencer state encoding
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Widest data word the formatting helper handles; callers zero-extend
    // their data to this width and truncate the result back.
    localparam int c_MAX_DATA_W = 256;

    // Zero-extending write formatter: byte and half keep only the low lanes,
    // full keeps the low 'width' bits. Upper bits are always cleared.
    function automatic logic [c_MAX_DATA_W-1:0] fmt_wdata(
        input logic [1:0]              size,
        input logic [c_MAX_DATA_W-1:0] data,
        input int                      width
    );
        logic [c_MAX_DATA_W-1:0] w_res;
        w_res = '0;
        case (size)
            SZ_BYTE: w_res[7:0]  = data[7:0];
            SZ_HALF: w_res[15:0] = data[15:0];
            default: begin
                for (int i = 0; i < c_MAX_DATA_W; i++) begin
                    if (i < width) begin
                        w_res[i] = data[i];
                    end
                end
            end
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_dp_param_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_dp_param_if
// Description : Bundle of the two request ports, their read-data returns and
//               the busy flag of the dual-port data memory.
//               master : requester (drives EN/WE/SIZE/DIR/DI)
//               slave  : memory    (drives DO/VLD/BUSY)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_dp_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic              EN1;
    logic              WE1;
    logic [1:0]        SIZE1;
    logic [ADDR_W-1:0] DIR1;
    logic [DATA_W-1:0] DI1;
    logic [DATA_W-1:0] DO1;
    logic              VLD1;

    logic              EN2;
    logic              WE2;
    logic [1:0]        SIZE2;
    logic [ADDR_W-1:0] DIR2;
    logic [DATA_W-1:0] DI2;
    logic [DATA_W-1:0] DO2;
    logic              VLD2;

    logic              BUSY;

    modport master (
        output EN1, WE1, SIZE1, DIR1, DI1,
        output EN2, WE2, SIZE2, DIR2, DI2,
        input  DO1, VLD1, DO2, VLD2, BUSY
    );

    modport slave (
        input  EN1, WE1, SIZE1, DIR1, DI1,
        input  EN2, WE2, SIZE2, DIR2, DI2,
        output DO1, VLD1, DO2, VLD2, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/mem_dp_param_clr.sv
`default_nettype none
// ============================================================================
// Module      : mem_dp_clr
// Description : Post-reset clear sequencer. In CLEAR it walks every word
//               address once (one per cycle) and then parks in READY until
//               the next reset.
//   clk        in  clock
//   rst        in  asynchronous active-high reset
//   o_busy     out high while the clear walk runs (registered)
//   o_clr_we   out clear write enable for the array
//   o_clr_addr out address being cleared this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dp_clr
    import mem_dp_pkg::*;
#(
    parameter int DEPTH      = 128,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int INIT_CLEAR = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    output logic                   o_busy,
    output logic                   o_clr_we,
    output logic [ADDR_W-1:0]      o_clr_addr
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [0:0]        c_RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_busy;

    // Entering READY happens on the same edge that clears the last word, so
    // the walk takes exactly DEPTH cycles after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_RST_STATE;
            r_clr_ptr <= '0;
            r_busy    <= (INIT_CLEAR != 0);
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_ptr == c_LAST_ADDR) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_clr_we   = r_busy;
    assign o_clr_addr = r_clr_ptr;

endmodule
`default_nettype wire

// File: rtl/mem_dp_param.sv
`default_nettype none
// ============================================================================
// Module      : mem_dp_param
// Description : Parametrised true-dual-port data memory. Each port reads or
//               writes a full/half/byte word (zero-extended, no lane merge)
//               with 1-cycle read latency and a read-valid strobe. A clear
//               sequencer zeroes the array after reset when INIT_CLEAR=1.
//   reloj  in  clock
//   reset  in  asynchronous active-high reset
//   bus    slave modport of mem_dp_param_if (EN/WE/SIZE/DIR/DI in,
//          DO/VLD/BUSY out, for ports 1 and 2)
// Collision rules (same address, same cycle):
//   write/write -> port 1 wins; read/read -> both see the word;
//   read/write  -> read-first, or write-first when MEM_FWD_EN is defined.
// Build option : `define MEM_FWD_EN to forward write data to a colliding read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dp_param
    import mem_dp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 128,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int INIT_CLEAR = 1
) (
    input  wire logic      reloj,
    input  wire logic      reset,
    mem_dp_param_if.slave  bus
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

    logic              w_in1, w_in2;
    logic              w_rd1, w_rd2;
    logic              w_wr1, w_wr2;
    logic              w_same;
    logic [DATA_W-1:0] w_wd1, w_wd2;
    logic [DATA_W-1:0] w_rdata1, w_rdata2;

    logic [DATA_W-1:0] r_do1, r_do2;
    logic              r_vld1, r_vld2;

    mem_dp_clr #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clr (
        .clk        (reloj),
        .rst        (reset),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Request decode; everything is ignored while the clear walk runs.
    assign w_in1  = ({1'b0, bus.DIR1} < c_DEPTH);
    assign w_in2  = ({1'b0, bus.DIR2} < c_DEPTH);
    assign w_rd1  = !w_busy && bus.EN1 && !bus.WE1;
    assign w_rd2  = !w_busy && bus.EN2 && !bus.WE2;
    assign w_wr1  = !w_busy && bus.EN1 &&  bus.WE1 && w_in1;
    assign w_wr2  = !w_busy && bus.EN2 &&  bus.WE2 && w_in2;
    assign w_same = (bus.DIR1 == bus.DIR2);

    assign w_wd1 = DATA_W'(fmt_wdata(bus.SIZE1, c_MAX_DATA_W'(bus.DI1), DATA_W));
    assign w_wd2 = DATA_W'(fmt_wdata(bus.SIZE2, c_MAX_DATA_W'(bus.DI2), DATA_W));

    // Array: the clear walk owns it while busy. Port 2 is suppressed on a
    // write/write collision so port 1 data is what lands.
    always_ff @(posedge reloj) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            if (w_wr2 && !(w_wr1 && w_same)) begin
                r_mem[bus.DIR2] <= w_wd2;
            end
            if (w_wr1) begin
                r_mem[bus.DIR1] <= w_wd1;
            end
        end
    end

    // Read data selection. Out-of-range reads return zero.
`ifdef MEM_FWD_EN
    // Write-first: a read colliding with the other port's write sees the
    // formatted write data instead of the stored word.
    always_comb begin
        w_rdata1 = '0;
        w_rdata2 = '0;
        if (w_in1) begin
            w_rdata1 = (w_wr2 && w_same) ? w_wd2 : r_mem[bus.DIR1];
        end
        if (w_in2) begin
            w_rdata2 = (w_wr1 && w_same) ? w_wd1 : r_mem[bus.DIR2];
        end
    end
`else
    // Read-first: the array is sampled before this edge's writes land.
    always_comb begin
        w_rdata1 = '0;
        w_rdata2 = '0;
        if (w_in1) begin
            w_rdata1 = r_mem[bus.DIR1];
        end
        if (w_in2) begin
            w_rdata2 = r_mem[bus.DIR2];
        end
    end
`endif

    // Output registers: DO only changes on a read, VLD pulses for one cycle.
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            r_do1  <= '0;
            r_do2  <= '0;
            r_vld1 <= 1'b0;
            r_vld2 <= 1'b0;
        end else begin
            r_vld1 <= w_rd1;
            r_vld2 <= w_rd2;
            if (w_rd1) begin
                r_do1 <= w_rdata1;
            end
            if (w_rd2) begin
                r_do2 <= w_rdata2;
            end
        end
    end

    assign bus.DO1  = r_do1;
    assign bus.DO2  = r_do2;
    assign bus.VLD1 = r_vld1;
    assign bus.VLD2 = r_vld2;
    assign bus.BUSY = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_dp_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_dp_param
// Description : Self-checking bench for mem_dp_param. Instance A: DEPTH=128,
//               instance B: DEPTH=100, both with INIT_CLEAR=1. Table-driven
//               port vectors plus hand-written clear/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dp_param;
    import mem_dp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    mem_dp_param_if #(.DATA_W(32), .ADDR_W(7)) bus_a ();
    mem_dp_param_if #(.DATA_W(32), .ADDR_W(7)) bus_b ();

    mem_dp_param #(.DATA_W(32), .DEPTH(128), .ADDR_W(7), .INIT_CLEAR(1)) u_a (
        .reloj (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    mem_dp_param #(.DATA_W(32), .DEPTH(100), .ADDR_W(7), .INIT_CLEAR(1)) u_b (
        .reloj (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

`ifdef MEM_FWD_EN
    localparam logic [31:0] c_COLL7  = 32'h0000_0055;
    localparam logic [31:0] c_COLL21 = 32'h0000_ABCD;
`else
    localparam logic [31:0] c_COLL7  = 32'hAAAA_0000;
    localparam logic [31:0] c_COLL21 = 32'h0000_0000;
`endif

    typedef struct {
        bit          dut;
        logic        en1;  logic we1;  logic [1:0] sz1;  logic [6:0] a1;  logic [31:0] d1;
        logic        en2;  logic we2;  logic [1:0] sz2;  logic [6:0] a2;  logic [31:0] d2;
        logic [31:0] do1;  logic vld1;
        logic [31:0] do2;  logic vld2;
    } vec_t;

    vec_t vecs[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_a.EN1 = 0; bus_a.WE1 = 0; bus_a.SIZE1 = SZ_FULL; bus_a.DIR1 = '0; bus_a.DI1 = '0;
        bus_a.EN2 = 0; bus_a.WE2 = 0; bus_a.SIZE2 = SZ_FULL; bus_a.DIR2 = '0; bus_a.DI2 = '0;
        bus_b.EN1 = 0; bus_b.WE1 = 0; bus_b.SIZE1 = SZ_FULL; bus_b.DIR1 = '0; bus_b.DI1 = '0;
        bus_b.EN2 = 0; bus_b.WE2 = 0; bus_b.SIZE2 = SZ_FULL; bus_b.DIR2 = '0; bus_b.DI2 = '0;
    endtask

    function automatic vec_t mk(
        input bit dut,
        input logic e1, input logic w1, input logic [1:0] s1, input logic [6:0] a1, input logic [31:0] d1,
        input logic e2, input logic w2, input logic [1:0] s2, input logic [6:0] a2, input logic [31:0] d2,
        input logic [31:0] o1, input logic v1, input logic [31:0] o2, input logic v2
    );
        vec_t v;
        v.dut = dut;
        v.en1 = e1; v.we1 = w1; v.sz1 = s1; v.a1 = a1; v.d1 = d1;
        v.en2 = e2; v.we2 = w2; v.sz2 = s2; v.a2 = a2; v.d2 = d2;
        v.do1 = o1; v.vld1 = v1; v.do2 = o2; v.vld2 = v2;
        return v;
    endfunction

    task automatic apply(input int idx, input vec_t v);
        logic [31:0] o1, o2;
        logic        l1, l2;
        idle_all();
        if (!v.dut) begin
            bus_a.EN1 = v.en1; bus_a.WE1 = v.we1; bus_a.SIZE1 = v.sz1; bus_a.DIR1 = v.a1; bus_a.DI1 = v.d1;
            bus_a.EN2 = v.en2; bus_a.WE2 = v.we2; bus_a.SIZE2 = v.sz2; bus_a.DIR2 = v.a2; bus_a.DI2 = v.d2;
        end else begin
            bus_b.EN1 = v.en1; bus_b.WE1 = v.we1; bus_b.SIZE1 = v.sz1; bus_b.DIR1 = v.a1; bus_b.DI1 = v.d1;
            bus_b.EN2 = v.en2; bus_b.WE2 = v.we2; bus_b.SIZE2 = v.sz2; bus_b.DIR2 = v.a2; bus_b.DI2 = v.d2;
        end
        tick();
        o1 = v.dut ? bus_b.DO1  : bus_a.DO1;
        o2 = v.dut ? bus_b.DO2  : bus_a.DO2;
        l1 = v.dut ? bus_b.VLD1 : bus_a.VLD1;
        l2 = v.dut ? bus_b.VLD2 : bus_a.VLD2;
        check($sformatf("v%0d DO1", idx),  o1, v.do1);
        check($sformatf("v%0d VLD1", idx), 32'(l1), 32'(v.vld1));
        check($sformatf("v%0d DO2", idx),  o2, v.do2);
        check($sformatf("v%0d VLD2", idx), 32'(l2), 32'(v.vld2));
        idle_all();
    endtask

    initial begin
        int  cnt;
        bit  vld_seen;

        idle_all();
        rst_a = 1'b1;
        rst_b = 1'b1;

        // dut, en1 we1 sz1 a1 d1, en2 we2 sz2 a2 d2, do1 vld1, do2 vld2
        vecs.push_back(mk(0, 1,0,SZ_FULL,0,0,            1,0,SZ_FULL,127,0,           32'h0,1, 32'h0,1));
        vecs.push_back(mk(0, 1,1,SZ_FULL,5,32'hDEADBEEF, 0,0,SZ_FULL,0,0,             32'h0,0, 32'h0,0));
        vecs.push_back(mk(0, 0,0,SZ_FULL,0,0,            1,0,SZ_FULL,5,0,             32'h0,0, 32'hDEADBEEF,1));
        vecs.push_back(mk(0, 0,0,SZ_FULL,0,0,            0,0,SZ_FULL,0,0,             32'h0,0, 32'hDEADBEEF,0));
        vecs.push_back(mk(0, 1,1,SZ_HALF,9,32'hDEADBEEF, 1,1,SZ_BYTE,10,32'h12345678, 32'h0,0, 32'hDEADBEEF,0));
        vecs.push_back(mk(0, 1,0,SZ_FULL,9,0,            1,0,SZ_FULL,10,0,            32'h0000BEEF,1, 32'h00000078,1));
        vecs.push_back(mk(0, 1,1,SZ_FULL,3,32'h11111111, 1,1,SZ_FULL,3,32'h22222222,  32'h0000BEEF,0, 32'h00000078,0));
        vecs.push_back(mk(0, 1,0,SZ_FULL,3,0,            1,0,SZ_FULL,3,0,             32'h11111111,1, 32'h11111111,1));
        vecs.push_back(mk(0, 1,1,SZ_FULL,7,32'hAAAA0000, 0,0,SZ_FULL,0,0,             32'h11111111,0, 32'h11111111,0));
        vecs.push_back(mk(0, 1,1,SZ_FULL,7,32'h00000055, 1,0,SZ_FULL,7,0,             32'h11111111,0, c_COLL7,1));
        vecs.push_back(mk(0, 1,0,SZ_FULL,9,0,            1,0,SZ_FULL,7,0,             32'h0000BEEF,1, 32'h00000055,1));
        vecs.push_back(mk(0, 1,0,SZ_FULL,5,0,            1,1,2'b11,20,32'hCAFEF00D,   32'hDEADBEEF,1, 32'h00000055,0));
        vecs.push_back(mk(0, 1,0,SZ_FULL,20,0,           0,0,SZ_FULL,0,0,             32'hCAFEF00D,1, 32'h00000055,0));
        vecs.push_back(mk(0, 1,0,SZ_FULL,21,0,           1,1,SZ_HALF,21,32'h1234ABCD, c_COLL21,1, 32'h00000055,0));
        vecs.push_back(mk(0, 1,0,SZ_FULL,21,0,           1,0,SZ_FULL,3,0,             32'h0000ABCD,1, 32'h11111111,1));
        vecs.push_back(mk(0, 1,1,SZ_BYTE,3,32'hFFFFFF99, 0,0,SZ_FULL,0,0,             32'h0000ABCD,0, 32'h11111111,0));
        vecs.push_back(mk(0, 0,0,SZ_FULL,0,0,            1,0,SZ_FULL,3,0,             32'h0000ABCD,0, 32'h00000099,1));
        vecs.push_back(mk(1, 1,1,SZ_FULL,120,32'h12345678, 1,1,SZ_FULL,99,32'h9ABC,   32'h0,0, 32'h0,0));
        vecs.push_back(mk(1, 1,0,SZ_FULL,99,0,           1,0,SZ_FULL,120,0,           32'h00009ABC,1, 32'h0,1));
        vecs.push_back(mk(1, 1,0,SZ_FULL,120,0,          1,0,SZ_FULL,99,0,            32'h0,1, 32'h00009ABC,1));
        vecs.push_back(mk(1, 1,0,SZ_FULL,98,0,           0,0,SZ_FULL,0,0,             32'h0,1, 32'h00009ABC,0));

        // ---- Instance A: reset state and full clear walk ----
        repeat (3) tick();
        check("rstA BUSY", 32'(bus_a.BUSY), 32'd1);
        check("rstA DO1",  bus_a.DO1, 32'h0);
        check("rstA VLD1", 32'(bus_a.VLD1), 32'd0);
        check("rstA VLD2", 32'(bus_a.VLD2), 32'd0);
        rst_a = 1'b0;

        // Requests during the walk must be ignored (no VLD, no write).
        bus_a.EN1 = 1; bus_a.WE1 = 0; bus_a.DIR1 = 7'd0;
        bus_a.EN2 = 1; bus_a.WE2 = 1; bus_a.DIR2 = 7'd0; bus_a.DI2 = 32'hFFFFFFFF;
        cnt = 0;
        vld_seen = 0;
        while (bus_a.BUSY && cnt < 300) begin
            tick();
            cnt++;
            if (bus_a.VLD1 || bus_a.VLD2) vld_seen = 1;
        end
        idle_all();
        check("clearA cycles", 32'(cnt), 32'd128);
        check("clearA ignored", 32'(vld_seen), 32'd0);

        for (int i = 0; i < 17; i++) begin
            apply(i, vecs[i]);
        end

        // ---- Instance B: reset mid-clear restarts the walk ----
        rst_b = 1'b0;
        repeat (40) tick();
        rst_b = 1'b1;
        #1;
        check("midrstB BUSY", 32'(bus_b.BUSY), 32'd1);
        repeat (2) tick();
        check("midrstB held", 32'(bus_b.BUSY), 32'd1);
        rst_b = 1'b0;
        cnt = 0;
        while (bus_b.BUSY && cnt < 300) begin
            tick();
            cnt++;
        end
        check("clearB cycles", 32'(cnt), 32'd100);

        for (int i = 17; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
